// File: rtl/phase_accumulator.sv
// NCO phase stage: converts a frequency in Hz to a DDS tuning word with a
// serial shift-add multiplier, then accumulates phase every enabled cycle.
module phase_accumulator #(
   parameter int unsigned PHASE_W  = 32,
   parameter int unsigned ADDR_W   = 10,
   parameter int unsigned K_MULT   = 720575940,
   parameter int unsigned K_SHIFT  = 24,
   parameter int unsigned FREQ_MAX = 50000000
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [31:0]        freq,
   input  logic               enable,
   input  logic               phase_rst,
   output logic [PHASE_W-1:0] phase,
   output logic [ADDR_W-1:0]  addr,
   output logic               wrap,
   output logic [31:0]        tuning,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MULT = 2'd1,
      S_LOAD = 2'd2
   } state_t;

   localparam logic [55:0] K_EXT = 56'(K_MULT);
   localparam logic [55:0] HALF  = 56'd1 << (K_SHIFT - 1);

   state_t      state;
   state_t      state_nxt;
   logic        start;
   logic [31:0] f_in;
   logic [31:0] f_cap;
   logic        pend;
   logic [55:0] prod;
   logic [55:0] mcand;
   logic [4:0]  cnt;

   assign f_in      = (freq > 32'(FREQ_MAX)) ? 32'(FREQ_MAX) : freq;
   assign addr      = phase[PHASE_W-1 -: ADDR_W];
   assign dbg_state = state;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // A pending request forces a restart even if the value changed back.
   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      case (state)
         S_IDLE: begin
            if ((f_in != f_cap) || pend) begin
               start     = 1'b1;
               state_nxt = S_MULT;
            end
         end
         S_MULT: if (cnt == 5'd31) state_nxt = S_LOAD;
         S_LOAD: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         f_cap  <= '0;
         pend   <= 1'b0;
         prod   <= '0;
         mcand  <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         tuning <= '0;
      end else if (start) begin
         f_cap <= f_in;
         prod  <= '0;
         mcand <= K_EXT;
         cnt   <= '0;
         busy  <= 1'b1;
         pend  <= 1'b0;
      end else if (state == S_MULT) begin
         if (f_cap[cnt]) prod <= prod + mcand;
         mcand <= mcand << 1;
         cnt   <= cnt + 5'd1;
         if (f_in != f_cap) pend <= 1'b1;
      end else if (state == S_LOAD) begin
         tuning <= 32'((prod + HALF) >> K_SHIFT);
         busy   <= 1'b0;
         if (f_in != f_cap) pend <= 1'b1;
      end
   end

   // Uses the tuning word as registered, so a coincident load takes effect next cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         phase <= '0;
         wrap  <= 1'b0;
      end else if (phase_rst) begin
         phase <= '0;
         wrap  <= 1'b0;
      end else if (enable) begin
         {wrap, phase} <= {1'b0, phase} + (PHASE_W + 1)'(tuning);
      end else begin
         wrap <= 1'b0;
      end
   end

endmodule

// File: doc/phase_accumulator.md
Name: phase_accumulator

Overview:
- Numerically controlled oscillator stage directly downstream of the frequency control block.
- Consumes the 32-bit FREQ word in Hz and converts it to a DDS tuning word with a sequential shift-add multiplier.
- Accumulates phase every clock and drives the waveform LUT address plus a cycle-wrap strobe for the waveform and display stages.
- Retunes glitch-free: the accumulator keeps running on the old tuning word until the new one is loaded in a single cycle.

Parameters:
- PHASE_W, 32: accumulator and tuning word width.
- ADDR_W, 10: LUT address width; ADDR is the top ADDR_W bits of PHASE.
- K_MULT, 720575940: round(2^56 / CLK_HZ) for CLK_HZ = 100 MHz; 30-bit constant.
- K_SHIFT, 24: right shift applied to the product.
- FREQ_MAX, 50000000: input clamp in Hz (Nyquist limit).

Ports:
- CLOCK  input  1  system clock, 100 MHz.
- RESET_N  input  1  asynchronous, active-low reset.
- FREQ  input  32  requested frequency in Hz, from the frequency control stage.
- ENABLE  input  1  when 1, phase advances; when 0, phase holds.
- PHASE_RST  input  1  synchronous phase clear.
- PHASE  output  PHASE_W  current phase accumulator value.
- ADDR  output  ADDR_W  PHASE[PHASE_W-1 -: ADDR_W], LUT address.
- WRAP  output  1  one-cycle pulse when the phase addition carries out.
- TUNING  output  32  tuning word currently in use.
- BUSY  output  1  high while a conversion is in progress.

Behaviour:
- Reset (RESET_N=0, asynchronous): all of the following are 0: PHASE, TUNING, WRAP, BUSY, state=IDLE, F_CAP (last captured freq), PEND.
- Clamp: F_IN = (FREQ > FREQ_MAX) ? FREQ_MAX : FREQ. This is combinational and applied before compare and capture.
- State machine:
  - IDLE -> MULT when F_IN != F_CAP, or when PEND=1.
    - On that edge: F_CAP <= F_IN, product register P (56 bits) <= 0, multiplicand M <= K_MULT, bit counter <= 0, BUSY <= 1, PEND <= 0.
  - MULT: 32 cycles, processing F_CAP LSB first.
    - If F_CAP[cnt]=1: P <= P + (M << cnt).
    - Counter increments. After cnt = 31 -> LOAD.
  - LOAD: TUNING <= (P + 2^(K_SHIFT-1)) >> K_SHIFT, truncated to 32 bits. BUSY <= 0. -> IDLE.
- Latency: TUNING changes exactly 34 rising edges after the first edge that samples a new F_IN in IDLE (1 capture + 32 MULT + 1 LOAD). BUSY is high for 33 cycles.
- FREQ change while BUSY:
  - Set PEND=1. The in-flight computation completes with the old F_CAP and loads.
  - IDLE then immediately restarts with the then-current F_IN.
  - Multiple changes during BUSY collapse into one pending recompute of the latest value.
- Accumulator, every cycle:
  - PHASE_RST=1: PHASE <= 0, WRAP <= 0. This has priority over ENABLE.
  - Else if ENABLE=1: {carry, PHASE} <= PHASE + TUNING; WRAP <= carry. Wrap-around is modulo 2^PHASE_W.
  - Else: PHASE holds, WRAP <= 0.
  - When a LOAD coincides with an accumulate, the add uses the old TUNING. The new TUNING is used from the next cycle.
- After reset with FREQ != 0, a conversion starts on the first edge after RESET_N deasserts.
- Reset asserted mid-conversion: abort, all state cleared, no partial TUNING load.
- TUNING = 0 (FREQ=0): PHASE frozen, WRAP never asserts.
- ADDR is purely combinational from PHASE.

Test Plan:
- Reset release with FREQ=10000000, ENABLE=0 -> BUSY rises next edge, held 33 cycles; TUNING = 429496729 (0x1999_9999) exactly 34 edges after the first sampling edge; PHASE stays 0.
- FREQ=1, ENABLE=1 -> TUNING=43; PHASE increments by 43 per cycle after load; ADDR = PHASE[31:22].
- FREQ=60000000 (over limit) -> clamped, TUNING = 2147483647 (0x7FFF_FFFF). With ENABLE=1 from PHASE=0: WRAP first pulses on the 3rd accumulate (PHASE goes 0x7FFFFFFF, 0xFFFFFFFE, 0x7FFFFFFD).
- During BUSY (cycle 10 of MULT), change FREQ 1000 -> 2000 -> 3000 -> first LOAD gives round(1000*K/2^24)=42950; one recompute follows; final TUNING=128849.
- ENABLE=1, TUNING loaded, assert PHASE_RST for 1 cycle with ENABLE=1 -> PHASE=0 that edge, WRAP=0, accumulation resumes next cycle.
- Assert RESET_N=0 at MULT cycle 15 -> PHASE, TUNING, BUSY, WRAP all 0 immediately (asynchronously); after release, conversion restarts from scratch with latency 34.
